uart_rom_streamer: RTL and testbench
====================================

Name: uart_rom_streamer

Overview:
- Self-contained transmit path that streams the contents of an internal read-only message memory over a UART TX line, one byte per frame, in ascending address order with wrap-around.
- Three internal parts:
  - synchronous ROM;
  - address sequencer that advances once per accepted frame;
  - 8N1-style UART transmitter clocked from the system clock.
- Sits at the board edge as a debug/identification message source.

Parameters:
- CLK_FREQ, 38400, system clock frequency in Hz.
- BAUDRATE, 9600, UART bit rate.
  - CPB = CLK_FREQ/BAUDRATE is the number of clocks per bit.
  - CPB must be an integer and at least 2; default CPB = 4.
- ADDR_WIDTH, 5, ROM address width; depth = 2**ADDR_WIDTH (32).
- DATA_WIDTH, 8, ROM word width and number of UART data bits per frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  streaming enable; sampled each cycle.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is on the line.
- addr  output  ADDR_WIDTH  ROM address of the next byte to send.
- tx_byte  output  DATA_WIDTH  byte latched for the current or last frame.
- frame_done  output  1  one-cycle pulse in the last cycle of a stop bit.

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-high (rst).

Reset:
- On a clk edge with rst=1:
  - tx=1, busy=0, addr=0, tx_byte=0, frame_done=0.
  - Bit and clock counters are cleared.
- Reset mid-frame aborts the frame: tx is high from the next cycle.

ROM:
- Word i = (0x41 + i) truncated to DATA_WIDTH. This gives 'A'..0x60 for the default depth.
- Read is synchronous with 1-cycle latency: the data register holds ROM[addr] one edge after addr is stable.
- A data-valid flag is set when addr has not changed on the previous edge. It is cleared on reset and on the edge that increments addr.

Start/accept:
- The transmitter is ready when busy=0.
- A frame is accepted on the edge where ready=1, en=1, valid=1, rst=0. On that edge:
  - tx_byte takes the ROM data;
  - addr increments by 1, wrapping 2**ADDR_WIDTH-1 -> 0;
  - busy goes 1.

Frame:
- tx is registered. Starting the cycle after acceptance:
  - start bit 0 for CPB cycles;
  - DATA_WIDTH data bits, LSB first, CPB cycles each;
  - one stop bit 1 for CPB cycles.
- Total frame length = (DATA_WIDTH+2)*CPB cycles.
- frame_done=1 in the final stop-bit cycle. busy=0 from the next cycle.
- No parity. tx=1 whenever not framing.

Back-to-back:
- With en held at 1, the next frame is accepted in the first ready cycle.
- Exactly one idle-high cycle separates frames, so the frame period is (DATA_WIDTH+2)*CPB+1 = 41 clocks for the defaults.

Enable:
- After reset, en must be high with valid=1 before the first accept. The first start bit appears on tx 2 cycles after rst is released with en=1.
- en only gates acceptance. Dropping en mid-frame lets the frame complete; no new frame starts.
- en changes never alter addr outside an accept.

Simultaneous events:
- rst has priority over everything.
- Accept and frame_done cannot coincide, because accept requires busy=0.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, en=0, run 100 cycles -> tx=1, busy=0, addr=0, frame_done never pulses.
2. First frame (defaults, CPB=4): release rst with en=1 ->
   - tx low for 4 cycles;
   - data bits 1,0,0,0,0,0,1,0 (0x41), each 4 cycles;
   - stop high 4 cycles;
   - tx_byte=0x41, addr=1 after accept, frame_done pulses once, busy high for exactly 40 cycles.
3. Streaming: en=1 for 5 frames -> decoded bytes 0x41,0x42,0x43,0x44,0x45; start bits 41 clocks apart; one idle cycle between frames.
4. Wrap-around: stream 33 frames -> byte 32 = 0x60 (addr 31), byte 33 = 0x41; addr wraps to 0 then 1.
5. Enable drop: deassert en in the middle of frame 2 -> frame 2 completes intact (0x42), tx then stays high, addr=2. Reassert en -> next byte 0x43.
6. Mid-frame reset: pulse rst during data bit 3 of a frame -> tx=1 on the next cycle, busy=0, addr=0. The next frame after release sends 0x41.

Source files
------------

// File: rtl/uart_rom_streamer.sv
// uart_rom_streamer: streams a fixed message ROM over an 8N1 UART TX line,
// one byte per frame, ascending address with wrap-around.
module uart_rom_streamer #(
    parameter int unsigned CLK_FREQ   = 38400,
    parameter int unsigned BAUDRATE   = 9600,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  tx,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  frame_done
);

    localparam int unsigned CPB      = CLK_FREQ / BAUDRATE;
    localparam int unsigned CNT_W    = $clog2(CPB);
    localparam int unsigned BIT_W    = $clog2(DATA_WIDTH + 2);
    // Bit slot 0 is the start bit, 1..DATA_WIDTH are data, STOP_SLOT is the stop bit
    localparam int unsigned STOP_SLOT = DATA_WIDTH + 1;

    // Message content: 'A' + address, truncated to the word width
    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(32'h41 + 32'(a));
    endfunction

    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                  frame_done_q, frame_done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  accept_c;

    // ROM read, address sequencing and bit timing of the transmitter
    always_comb begin
        tx_d         = tx_q;
        busy_d       = busy_q;
        addr_d       = addr_q;
        tx_byte_d    = tx_byte_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        data_d       = rom_word(addr_q);
        valid_d      = 1'b1;
        frame_done_d = 1'b0;
        accept_c     = !busy_q && en && valid_q;

        if (accept_c) begin
            // Address moves this edge, so the ROM data register is stale next cycle
            tx_byte_d = data_q;
            shreg_d   = data_q;
            addr_d    = addr_q + ADDR_WIDTH'(1);
            busy_d    = 1'b1;
            cnt_d     = '0;
            bit_d     = '0;
            tx_d      = 1'b0;
            valid_d   = 1'b0;
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(CPB - 1)) begin
                cnt_d = '0;
                if (bit_q == BIT_W'(STOP_SLOT)) begin
                    busy_d = 1'b0;
                    bit_d  = '0;
                    tx_d   = 1'b1;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == '0) begin
                        tx_d = shreg_q[0];
                    end else if (bit_q < BIT_W'(DATA_WIDTH)) begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Flag the cycle that will be the last clock of the stop bit
        frame_done_d = busy_d && (bit_d == BIT_W'(STOP_SLOT)) && (cnt_d == CNT_W'(CPB - 1));
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            tx_byte_q    <= '0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            tx_byte_q    <= tx_byte_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign addr       = addr_q;
    assign tx_byte    = tx_byte_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_rom_streamer.sv
// Bench for uart_rom_streamer: frame-offset model, UART receiver, directed tests.
module tb_uart_rom_streamer;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          tx;
    logic          busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] tx_byte;
    logic          frame_done;

    uart_rom_streamer #(
        .CLK_FREQ  (38400),
        .BAUDRATE  (9600),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tx        (tx),
        .busy      (busy),
        .addr      (addr),
        .tx_byte   (tx_byte),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: a frame is a time offset since the accepting edge
    int m_init  = 0;
    int m_busy  = 0;
    int m_t     = 0;
    int m_addr  = 0;
    int m_byte  = 0;
    int m_valid = 0;

    always @(posedge clk) begin
        int acc;
        if (rst) begin
            m_init = 1; m_busy = 0; m_t = 0; m_addr = 0; m_byte = 0; m_valid = 0;
        end else begin
            acc = (!m_busy && en && m_valid) ? 1 : 0;
            if (m_busy) begin
                m_t = m_t + 1;
                if (m_t == FRAME) m_busy = 0;
            end else if (acc != 0) begin
                m_byte = (8'h41 + m_addr) & 8'hFF;
                m_addr = (m_addr + 1) % (1 << AW);
                m_busy = 1;
                m_t    = 0;
            end
            m_valid = (acc == 0) ? 1 : 0;
        end
    end

    function automatic int model_tx();
        int slot;
        if (!m_busy) return 1;
        slot = m_t / CPB;
        if (slot == 0) return 0;
        if (slot <= DW) return (m_byte >> (slot - 1)) & 1;
        return 1;
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_init != 0) begin
            check("tx", 32'(tx), 32'(model_tx()));
            check("busy", 32'(busy), 32'(m_busy));
            check("addr", 32'(addr), 32'(m_addr));
            check("tx_byte", 32'(tx_byte), 32'(m_byte));
            check("frame_done", 32'(frame_done), (m_busy != 0 && m_t == FRAME - 1) ? 32'd1 : 32'd0);
        end
    end

    // Line monitor: UART receiver plus busy/frame_done bookkeeping
    int       rx_q[$];
    int       starts[$];
    int       acc_addr[$];
    int       rx_act = 0;
    int       rx_t = 0;
    logic [7:0] rx_sh = '0;
    logic     prev_tx = 1'b1;
    logic     prev_busy = 1'b0;
    int       run_len = 0;
    int       last_busy_run = 0;
    int       fd_total = 0;

    always @(negedge clk) begin
        if (m_init != 0) begin
            if (rx_act != 0) begin
                rx_t++;
                if (!busy) begin
                    rx_act = 0;
                end else if (rx_t == CPB * (DW + 1) + CPB / 2) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    rx_q.push_back(int'(rx_sh));
                    rx_act = 0;
                end else if (rx_t % CPB == CPB / 2 && rx_t > CPB) begin
                    rx_sh = {tx, rx_sh[7:1]};
                end
            end else if (prev_tx && !tx) begin
                rx_act = 1;
                rx_t   = 0;
                starts.push_back(cyc);
            end
            if (busy && !prev_busy) acc_addr.push_back(int'(addr));
            if (busy) run_len++;
            else if (run_len > 0) begin
                last_busy_run = run_len;
                run_len = 0;
            end
            if (frame_done) fd_total++;
            prev_tx   = tx;
            prev_busy = busy;
        end
    end

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (starts.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("start_count", 32'(starts.size()), 32'(n));
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int rel;
        int br;
        int bs;
        int s;

        // Test 1: reset then idle with en low
        apply_reset(2);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_addr", 32'(addr), 32'd0);
        check("idle_fd", 32'(fd_total), 32'd0);

        // Test 2: first frame right after reset release with en high
        apply_reset(2);
        rst = 1'b0;
        en  = 1'b1;
        rel = cyc;
        repeat (2) @(negedge clk);
        check("first_start_tx", 32'(tx), 32'd0);
        check("first_addr", 32'(addr), 32'd1);
        check("first_tx_byte", 32'(tx_byte), 32'h41);
        check("first_busy", 32'(busy), 32'd1);
        wait_rx(1, 200);
        check("first_start_latency", 32'(starts[0] - rel), 32'd2);
        check("first_byte", 32'(rx_q[0]), 32'h41);
        repeat (4) @(negedge clk);
        check("first_busy_len", 32'(last_busy_run), 32'd40);
        check("first_fd_count", 32'(fd_total), 32'd1);

        // Test 3: streaming five frames
        wait_rx(5, 400);
        for (int i = 0; i < 5; i++) check("stream_byte", 32'(rx_q[i]), 32'(8'h41 + i));
        for (int i = 1; i < 5; i++) check("stream_period", 32'(starts[i] - starts[i-1]), 32'd41);

        // Test 4: wrap-around after 32 frames
        wait_rx(33, 1600);
        check("wrap_byte32", 32'(rx_q[31]), 32'h60);
        check("wrap_byte33", 32'(rx_q[32]), 32'h41);
        check("wrap_addr0", 32'(acc_addr[31]), 32'd0);
        check("wrap_addr1", 32'(acc_addr[32]), 32'd1);

        // Test 5: drop en during frame 2, then reassert
        apply_reset(2);
        br = rx_q.size();
        bs = starts.size();
        rst = 1'b0;
        en  = 1'b1;
        wait_starts(bs + 2, 200);
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_rx(br + 2, 200);
        repeat (60) @(negedge clk);
        check("drop_no_new_start", 32'(starts.size()), 32'(bs + 2));
        check("drop_tx_idle", 32'(tx), 32'd1);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_addr", 32'(addr), 32'd2);
        check("drop_byte1", 32'(rx_q[br]), 32'h41);
        check("drop_byte2", 32'(rx_q[br+1]), 32'h42);
        en = 1'b1;
        wait_rx(br + 3, 200);
        check("resume_byte", 32'(rx_q[br+2]), 32'h43);

        // Test 6: reset during data bit 3 of a frame
        apply_reset(2);
        rst = 1'b0;
        en  = 1'b1;
        bs = starts.size();
        wait_starts(bs + 1, 200);
        s = starts[bs];
        while (cyc < s + 17) @(negedge clk);
        br = rx_q.size();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        rst = 1'b0;
        wait_rx(br + 1, 200);
        check("mid_rst_next_byte", 32'(rx_q[br]), 32'h41);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
